// File: rtl/imem_sync_loadable_if.sv
// Fetch and program-load bus of the loadable instruction memory.
// The master is the fetch/loader side; the slave is the memory.
interface imem_sync_loadable_if #(
    parameter int N      = 32,
    parameter int ADDR_W = 6
) ();
    logic              rd_en;
    logic [ADDR_W-1:0] addr;
    logic [N-1:0]      q;
    logic              q_valid;
    logic              prog_we;
    logic [ADDR_W-1:0] prog_addr;
    logic [N-1:0]      prog_data;
    logic              ready;
    logic              parity_err;

    modport master (
        output rd_en, addr, prog_we, prog_addr, prog_data,
        input  q, q_valid, ready, parity_err
    );

    modport slave (
        input  rd_en, addr, prog_we, prog_addr, prog_data,
        output q, q_valid, ready, parity_err
    );
endinterface

// File: rtl/imem_sync_loadable.sv
// Synchronous loadable instruction memory: self-clearing sweep after reset, then
// program loads and one-cycle registered fetches. Optional parity: IMEM_PARITY_EN.
module imem_sync_loadable #(
    parameter int N      = 32,
    parameter int ADDR_W = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    imem_sync_loadable_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        ST_CLEAR,
        ST_READY
    } state_t;

    state_t            state_reg;
    logic [ADDR_W-1:0] clr_cnt_reg;
    logic [N-1:0]      q_reg;
    logic              q_valid_reg;
    logic              ready_reg;

    logic [N-1:0]      mem [DEPTH];

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [N-1:0]      wr_data;
    logic              fetch;

    // One shared write port: the clear sweep owns it until READY, then the loader.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = clr_cnt_reg;
        wr_data = '0;
        fetch   = 1'b0;
        if (state_reg == ST_CLEAR) begin
            wr_en = 1'b1;
        end else begin
            wr_en   = bus.prog_we;
            wr_addr = bus.prog_addr;
            wr_data = bus.prog_data;
            fetch   = bus.rd_en;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= ST_CLEAR;
            clr_cnt_reg <= '0;
            q_reg       <= '0;
            q_valid_reg <= 1'b0;
            ready_reg   <= 1'b0;
        end else begin
            case (state_reg)
                ST_CLEAR: begin
                    // Leave on the last word so the counter never wraps back to 0.
                    if (clr_cnt_reg == LAST_ADDR) begin
                        state_reg <= ST_READY;
                        ready_reg <= 1'b1;
                    end else begin
                        clr_cnt_reg <= clr_cnt_reg + 1'b1;
                    end
                end
                ST_READY: begin
                    // Read-first: the memory write of this edge is not yet visible here.
                    if (fetch) begin
                        q_reg       <= mem[bus.addr];
                        q_valid_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= ST_CLEAR;
                    ready_reg <= 1'b0;
                end
            endcase
        end
    end

    assign bus.q       = q_reg;
    assign bus.q_valid = q_valid_reg;
    assign bus.ready   = ready_reg;

`ifdef IMEM_PARITY_EN
    logic mem_par [DEPTH];
    logic parity_err_reg;

    // Even parity of the data being written; clear writes zero so parity is 0.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_par[wr_addr] <= ^wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            parity_err_reg <= 1'b0;
        end else if (fetch) begin
            parity_err_reg <= (^mem[bus.addr]) ^ mem_par[bus.addr];
        end
    end

    assign bus.parity_err = parity_err_reg;
`else
    assign bus.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_imem_sync_loadable.sv
// Directed bench for imem_sync_loadable: clear sweep timing, loads, fetches,
// stalls, read-first collision, reset during READY/CLEAR, optional parity.
module tb_imem_sync_loadable;
    localparam int N      = 32;
    localparam int ADDR_W = 6;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    imem_sync_loadable_if #(.N(N), .ADDR_W(ADDR_W)) bus ();

    imem_sync_loadable #(.N(N), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    // Counts edges until ready rises; q/q_valid must stay 0 throughout the sweep.
    task automatic wait_ready(input string tag, input int exp_cycles);
        int cyc;
        logic seen_nonzero;
        cyc = 0;
        seen_nonzero = 1'b0;
        while (bus.ready !== 1'b1 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (bus.q !== '0 || bus.q_valid !== 1'b0) seen_nonzero = 1'b1;
        end
        check({tag, "_clear_cycles"}, 32'(cyc), 32'(exp_cycles));
        check({tag, "_clear_q_zero"}, {31'd0, seen_nonzero}, 32'd0);
    endtask

    task automatic write_word(input logic [ADDR_W-1:0] a, input logic [N-1:0] d);
        bus.prog_we   = 1'b1;
        bus.prog_addr = a;
        bus.prog_data = d;
        bus.rd_en     = 1'b0;
        @(negedge clk);
        bus.prog_we   = 1'b0;
    endtask

    task automatic fetch_word(input logic [ADDR_W-1:0] a);
        bus.rd_en = 1'b1;
        bus.addr  = a;
        @(negedge clk);
        bus.rd_en = 1'b0;
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        reset         = 1'b1;
        bus.rd_en     = 1'b1;
        bus.addr      = 6'd5;
        bus.prog_we   = 1'b0;
        bus.prog_addr = '0;
        bus.prog_data = '0;
        repeat (3) @(negedge clk);

        check("rst_q", bus.q, 32'h0);
        check("rst_q_valid", {31'd0, bus.q_valid}, 32'd0);
        check("rst_ready", {31'd0, bus.ready}, 32'd0);
        check("rst_parity_err", {31'd0, bus.parity_err}, 32'd0);

        // 1) clear sweep with rd_en held high, then first fetch of addr 5
        reset = 1'b0;
        wait_ready("t1", 64);
        fetch_word(6'd5);
        check("t1_fetch5_q", bus.q, 32'h0);
        check("t1_fetch5_valid", {31'd0, bus.q_valid}, 32'd1);

        // 2) program load then fetch
        write_word(6'd0, 32'h8b0a03ea);
        write_word(6'd21, 32'hf805000a);
        fetch_word(6'd0);
        check("t2_fetch0_q", bus.q, 32'h8b0a03ea);
        check("t2_fetch0_valid", {31'd0, bus.q_valid}, 32'd1);
        fetch_word(6'd21);
        check("t2_fetch21_q", bus.q, 32'hf805000a);
        check("t2_fetch21_valid", {31'd0, bus.q_valid}, 32'd1);
        check("t2_parity_err", {31'd0, bus.parity_err}, 32'd0);

        // 3) stall holds q while addr changes
        fetch_word(6'd0);
        check("t3_fetch0_q", bus.q, 32'h8b0a03ea);
        bus.addr = 6'd1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("t3_stall%0d_q", i), bus.q, 32'h8b0a03ea);
        end
        check("t3_stall_valid", {31'd0, bus.q_valid}, 32'd1);

        // 4) same-cycle write and fetch of addr 7: read-first
        bus.prog_we   = 1'b1;
        bus.prog_addr = 6'd7;
        bus.prog_data = 32'h8b1f03ff;
        bus.rd_en     = 1'b1;
        bus.addr      = 6'd7;
        @(negedge clk);
        bus.prog_we = 1'b0;
        bus.rd_en   = 1'b0;
        check("t4_collide_q", bus.q, 32'h0);
        fetch_word(6'd7);
        check("t4_refetch7_q", bus.q, 32'h8b1f03ff);

        // 5) reset in READY, write during CLEAR is dropped
        reset = 1'b1;
        @(negedge clk);
        check("t5_rst_ready", {31'd0, bus.ready}, 32'd0);
        check("t5_rst_q", bus.q, 32'h0);
        check("t5_rst_q_valid", {31'd0, bus.q_valid}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        write_word(6'd3, 32'h00001234);
        bus.rd_en = 1'b1;
        bus.addr  = 6'd21;
        // 62 edges of the sweep remain after the two above
        wait_ready("t5", 62);
        bus.rd_en = 1'b0;
        fetch_word(6'd3);
        check("t5_fetch3_q", bus.q, 32'h0);

        // reset mid-CLEAR restarts the sweep and zeroes loaded contents
        write_word(6'd9, 32'hdeadbeef);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        check("t5b_midclear_ready", {31'd0, bus.ready}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        wait_ready("t5b", 64);
        fetch_word(6'd9);
        check("t5b_fetch9_q", bus.q, 32'h0);
        fetch_word(6'd63);
        check("t5b_fetch63_q", bus.q, 32'h0);

`ifdef IMEM_PARITY_EN
        // 6) corrupt a stored bit, then a clean fetch clears the flag
        write_word(6'd2, 32'h00000003);
        write_word(6'd0, 32'h8b0a03ea);
        dut.mem[2] = dut.mem[2] ^ 32'h00000010;
        fetch_word(6'd2);
        check("t6_parity_err_set", {31'd0, bus.parity_err}, 32'd1);
        fetch_word(6'd0);
        check("t6_parity_err_clean", {31'd0, bus.parity_err}, 32'd0);
        check("t6_clean_q", bus.q, 32'h8b0a03ea);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard time limit so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
